// File: rtl/word_serializer.sv
// word_serializer: splits a 64*WIDTH-bit word into four 16*WIDTH-bit beats, least-significant slice first
module word_serializer #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [64*WIDTH-1:0]   load_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WIDTH-1:0]   out_data,
  output logic                  out_last,
  output logic                  busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [64*WIDTH-1:0]   hold_q, hold_d;
  logic [16*WIDTH-1:0]   beat [4];
  logic                  load, xfer;
  for (genvar i = 0; i < 4; i++) begin : g_beat
    assign beat[i] = hold_q[16*WIDTH*i +: 16*WIDTH];
  end
  // Outputs follow the registered state; a new word may load on the edge that retires the final beat
  always_comb begin
    out_valid  = state_q == SEND;
    out_last   = out_valid && cnt_q == 2'd3;
    busy       = out_valid;
    load_ready = !out_valid || (out_last && out_ready);
    out_data   = out_valid ? beat[cnt_q] : '0;
    load       = load_valid && load_ready;
    xfer       = out_valid && out_ready;
    state_d    = load ? SEND : (xfer && out_last) ? IDLE : state_q;
    cnt_d      = load ? 2'd0 : xfer ? cnt_q + 2'd1 : cnt_q;
    hold_d     = load ? load_data : hold_q;
  end
  // State, beat counter and holding register, cleared asynchronously by an active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end
endmodule
